md_sequencer: RTL and testbench
===============================

# md_sequencer

Multi-cycle multiply/divide sequencer for the E stage of the five-stage MIPS pipeline. Captures operands when `mult`/`multu`/`div`/`divu` enters E, models fixed operation latency with a busy counter, and commits results to architectural HI/LO. Serves `mfhi`/`mflo`/`mthi`/`mtlo`. Raises a stall request to the hazard unit whenever the instruction in D needs HI/LO while an operation is starting or in flight.

## Interface
Parameters:
- `MULT_CYCLES`, 5 — busy cycles for `mult`/`multu` (1..15)
- `DIV_CYCLES`, 10 — busy cycles for `div`/`divu` (1..15)

Ports:
- `clk` input 1 — single clock, rising-edge
- `reset` input 1 — synchronous, active-high
- `OpD` input 6 — opcode of instruction in D
- `FunctD` input 6 — funct of instruction in D
- `OpE` input 6 — opcode of instruction in E
- `FunctE` input 6 — funct of instruction in E
- `ValidE` input 1 — E holds a real instruction (0 for bubble)
- `A` input 32 — forwarded rs value in E
- `B` input 32 — forwarded rt value in E
- `Start` output 1 — combinational: multiply/divide accepted this cycle
- `Busy` output 1 — registered: operation in flight
- `MDStallD` output 1 — combinational stall request for D
- `HI` output 32 — architectural HI register
- `LO` output 32 — architectural LO register

## Operation
- Decode with `OpE == 6'b000000`. Funct: `mult` 011000, `multu` 011001, `div` 011010, `divu` 011011, `mfhi` 010000, `mthi` 010001, `mflo` 010010, `mtlo` 010011.
- States: IDLE and RUN. The 4-bit down-counter `cnt` is internal.
- IDLE: `Start = ValidE && (mult/multu/div/divu in E) && !Busy`. On `Start`:
  - capture the result from `A`/`B` into pending registers;
  - load `cnt` with N−1 (N = `MULT_CYCLES` or `DIV_CYCLES`);
  - go to RUN.
- RUN: `Busy=1`. Decrement `cnt` each cycle. When `cnt==0`: write pending to HI/LO and return to IDLE.
- Operand changes during RUN do not affect the result.
- Multiply results:
  - `mult`: signed 32×32 → 64; HI = product[63:32], LO = product[31:0].
  - `multu`: unsigned 32×32 → 64; same split.
- Divide results:
  - `div`: signed, truncates toward zero. LO = quotient; HI = remainder with the sign of the dividend.
  - `divu`: unsigned; LO = quotient, HI = remainder.
- Divide boundary cases:
  - `div` 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - Divisor 0 (signed or unsigned): the operation still runs full latency, and HI/LO are left unchanged at commit.
- `mthi`/`mtlo` with `ValidE` and `!Busy` write `A` to HI/LO at the clock edge. While `Busy` they are ignored; the stall logic guarantees this never occurs.
- `mfhi`/`mflo` read `HI`/`LO` directly; the external mux selects.
- `MDStallD = (any of the eight HI/LO funct codes in D with OpD==0) && (Start || Busy)`.
- Reset: go to IDLE, `cnt=0`, `Busy=0`, HI=LO=0, pending registers cleared. An in-flight operation is discarded.

## Timing
- `Start` is asserted in cycle T. `Busy` is high in cycles T+1..T+N, i.e. exactly N cycles.
- HI/LO update on the edge ending cycle T+N and are visible from T+N+1.
- `MDStallD` is high in cycles T..T+N whenever D holds a HI/LO instruction. It is low from T+N+1, so a `mfhi` held in D reads committed data.
- `mthi`/`mtlo`: visible the cycle after E.
- `Start` and `Busy` are never both 1.
- A `Start` in the same cycle as `reset` is dropped.
- A non-HI/LO instruction in D never stalls; independent instructions flow during `Busy`.

## Configuration
- `MD_DIV_EN` defined: `div`/`divu` are implemented as above.
- `MD_DIV_EN` undefined:
  - `div`/`divu` are treated as no-ops: no `Start`, no `Busy`, HI/LO unchanged;
  - they do not contribute to the `MDStallD` decode in D;
  - no divider logic is synthesized, and `DIV_CYCLES` is unused.

## Test plan
- **Reset:** assert `reset` during RUN of a `mult` → next cycle `Busy=0`, HI=LO=0, and no later commit.
- **mult:** `mult` A=0xFFFFFFFE, B=3 → `Busy` for exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA. A `multu` with the same operands → HI=0x00000002, LO=0xFFFFFFFA.
- **div:** `div` A=-7 (0xFFFFFFF9), B=2 → after 10 busy cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF. A `divu` 0x80000000 / 0xFFFFFFFF → LO=0, HI=0x80000000.
- **Divide by zero:** `div` A=5, B=0 with HI=0x11, LO=0x22 → `Busy` for 10 cycles, HI/LO stay 0x11/0x22.
- **Stall:** `mult` in E with `mflo` in D → `MDStallD=1` for 6 cycles (T..T+5), and `mflo` sees the new LO. An `addu` in D during `Busy` → `MDStallD=0`.
- **mthi/mtlo:** `mthi` A=0xDEADBEEF in IDLE → HI=0xDEADBEEF next cycle, LO unchanged. With `MD_DIV_EN` undefined, a `div` in E → `Start=0`, `Busy=0`, HI/LO unchanged.

Source files
------------

// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle multiply/divide sequencer for the E stage.
// Captures the result when an MD operation enters E, holds Busy for a
// fixed latency, then commits to HI/LO. Serves mthi/mtlo and requests a
// D-stage stall for HI/LO consumers while an operation is starting or in flight.
// Optional feature: define MD_DIV_EN to implement div/divu; otherwise they are no-ops.
module md_sequencer #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  OpD,
  input  logic [5:0]  FunctD,
  input  logic [5:0]  OpE,
  input  logic [5:0]  FunctE,
  input  logic        ValidE,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        Start,
  output logic        Busy,
  output logic        MDStallD,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
`ifdef MD_DIV_EN
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        busy;
  logic [31:0] hi, lo;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_we;

  logic        rtype_e, is_mult_e, is_div_e, md_op_e, mthi_e, mtlo_e;
  logic        hilo_d;
  logic        ax, bx;
  logic [63:0] ae, be, prod;
  logic [31:0] res_hi, res_lo;
  logic        res_we;

  assign rtype_e   = (OpE == 6'b000000);
  assign is_mult_e = rtype_e && ((FunctE == F_MULT) || (FunctE == F_MULTU));
  assign mthi_e    = rtype_e && (FunctE == F_MTHI);
  assign mtlo_e    = rtype_e && (FunctE == F_MTLO);
`ifdef MD_DIV_EN
  assign is_div_e  = rtype_e && ((FunctE == F_DIV) || (FunctE == F_DIVU));
  assign hilo_d    = (OpD == 6'b000000) &&
                     ((FunctD == F_MFHI) || (FunctD == F_MTHI) || (FunctD == F_MFLO) ||
                      (FunctD == F_MTLO) || (FunctD == F_MULT) || (FunctD == F_MULTU) ||
                      (FunctD == F_DIV)  || (FunctD == F_DIVU));
`else
  assign is_div_e  = 1'b0;
  assign hilo_d    = (OpD == 6'b000000) &&
                     ((FunctD == F_MFHI) || (FunctD == F_MTHI) || (FunctD == F_MFLO) ||
                      (FunctD == F_MTLO) || (FunctD == F_MULT) || (FunctD == F_MULTU));
`endif
  assign md_op_e   = is_mult_e || is_div_e;

  assign Start    = ValidE && md_op_e && !busy;
  assign Busy     = busy;
  assign MDStallD = hilo_d && (Start || busy);
  assign HI       = hi;
  assign LO       = lo;

  // One shared multiplier: funct bit 0 selects zero- (multu) or sign-extension (mult);
  // the low 64 bits of the 64x64 product are the exact 32x32 result either way.
  assign ax   = !FunctE[0] && A[31];
  assign bx   = !FunctE[0] && B[31];
  assign ae   = {{32{ax}}, A};
  assign be   = {{32{bx}}, B};
  assign prod = ae * be;

`ifdef MD_DIV_EN
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  // Signed divide via magnitudes: quotient truncates toward zero, remainder takes dividend sign.
  always_comb begin
    a_neg = !FunctE[0] && A[31];
    b_neg = !FunctE[0] && B[31];
    a_mag = a_neg ? (~A + 32'd1) : A;
    b_mag = b_neg ? (~B + 32'd1) : B;
    q_mag = '0;
    r_mag = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    quot = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem  = a_neg ? (~r_mag + 32'd1) : r_mag;
  end
`endif

  // Result selection for the operation in E; divide by zero suppresses the commit.
  always_comb begin
    res_hi = prod[63:32];
    res_lo = prod[31:0];
    res_we = 1'b1;
`ifdef MD_DIV_EN
    if (is_div_e) begin
      res_hi = rem;
      res_lo = quot;
      res_we = (B != '0);
    end
`endif
  end

  // Sequencer: capture on Start, count latency in RUN, commit pending result to HI/LO.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      busy    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      pend_hi <= '0;
      pend_lo <= '0;
      pend_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            pend_hi <= res_hi;
            pend_lo <= res_lo;
            pend_we <= res_we;
            cnt     <= is_mult_e ? 4'(MULT_CYCLES - 1) : 4'(DIV_CYCLES - 1);
            busy    <= 1'b1;
            state   <= RUN;
          end else if (ValidE && mthi_e) begin
            hi <= A;
          end else if (ValidE && mtlo_e) begin
            lo <= A;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            if (pend_we) begin
              hi <= pend_hi;
              lo <= pend_lo;
            end
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: directed stimulus with a scoreboard; a monitor pops the
// expected HI/LO and busy length whenever Busy falls.
module tb_md_sequencer;

  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADDU  = 6'b100001;
`ifdef MD_DIV_EN
  localparam int DIV_D_STALL = 6;
`else
  localparam int DIV_D_STALL = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  OpD, FunctD, OpE, FunctE;
  logic        ValidE;
  logic [31:0] A, B;
  logic        Start, Busy, MDStallD;
  logic [31:0] HI, LO;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   busy_cnt = 0;

  md_sequencer #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .OpD(OpD), .FunctD(FunctD), .OpE(OpE), .FunctE(FunctE),
    .ValidE(ValidE), .A(A), .B(B), .Start(Start), .Busy(Busy), .MDStallD(MDStallD),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: counts busy cycles and scores each commit against the queue.
  always @(negedge clk) begin
    if (Busy === 1'b1) begin
      busy_cnt++;
    end else begin
      if (busy_cnt > 0) begin
        if (q.size() == 0) begin
          check("unexpected_commit", 64'(busy_cnt), 64'd0);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("commit_hi", 64'(HI), 64'(e.hi));
          check("commit_lo", 64'(LO), 64'(e.lo));
          if (e.n > 0) check("busy_len", 64'(busy_cnt), 64'(e.n));
        end
      end
      busy_cnt = 0;
    end
    if (reset === 1'b0) check("start_busy_excl", 64'(Start && Busy), 64'd0);
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Issue one MD op with fd in D; wait for completion and check stall length.
  task automatic run_md(input logic [5:0] fe, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] fd, input logic [31:0] ehi, input logic [31:0] elo,
                        input int n, input int estall);
    int stalls = 0;
    bit done = 0;
    exp_t e;
    cyc();
    OpE = 6'd0; FunctE = fe; ValidE = 1'b1; A = a; B = b; OpD = 6'd0; FunctD = fd;
    e.hi = ehi; e.lo = elo; e.n = n;
    q.push_back(e);
    @(negedge clk);
    check("start", 64'(Start), 64'd1);
    if (MDStallD) stalls++;
    cyc();
    ValidE = 1'b0; FunctE = F_ADDU; A = $urandom; B = $urandom;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      if (!Busy) done = 1;
      else if (MDStallD) stalls++;
    end
    if (!done) check("busy_timeout", 64'(Busy), 64'd0);
    check("stall_len", 64'(stalls), 64'(estall));
    FunctD = F_ADDU;
  endtask

  task automatic move_to(input logic [5:0] fe, input logic [31:0] a,
                         input logic [31:0] ehi, input logic [31:0] elo);
    cyc();
    OpE = 6'd0; FunctE = fe; ValidE = 1'b1; A = a;
    cyc();
    ValidE = 1'b0; FunctE = F_ADDU; A = $urandom;
    @(negedge clk);
    check("mt_hi", 64'(HI), 64'(ehi));
    check("mt_lo", 64'(LO), 64'(elo));
  endtask

  initial begin
    reset = 1'b1; OpD = 6'd0; FunctD = F_ADDU; OpE = 6'd0; FunctE = F_ADDU;
    ValidE = 1'b0; A = '0; B = '0;
    cyc(); cyc();
    reset = 1'b0;
    @(negedge clk);
    check("rst_busy", 64'(Busy), 64'd0);
    check("rst_hi", 64'(HI), 64'd0);
    check("rst_lo", 64'(LO), 64'd0);

    move_to(F_MTHI, 32'hDEADBEEF, 32'hDEADBEEF, 32'h0);

    run_md(F_MULT,  32'hFFFFFFFE, 32'd3, F_MFLO, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, 6);
    run_md(F_MULTU, 32'hFFFFFFFE, 32'd3, F_ADDU, 32'h00000002, 32'hFFFFFFFA, 5, 0);
    run_md(F_MULT,  32'h80000000, 32'h80000000, F_MFHI, 32'h40000000, 32'h0, 5, 6);
    run_md(F_MULT,  32'h12345678, 32'h10, F_DIV, 32'h1, 32'h23456780, 5, DIV_D_STALL);

`ifdef MD_DIV_EN
    run_md(F_DIV,  32'hFFFFFFF9, 32'd2, F_MFLO, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, 11);
    run_md(F_DIVU, 32'h80000000, 32'hFFFFFFFF, F_ADDU, 32'h80000000, 32'h0, 10, 0);
    run_md(F_DIV,  32'h80000000, 32'hFFFFFFFF, F_ADDU, 32'h0, 32'h80000000, 10, 0);
    run_md(F_DIVU, 32'd100, 32'd7, F_ADDU, 32'd2, 32'd14, 10, 0);
    move_to(F_MTHI, 32'h11, 32'h11, 32'h80000000);
    move_to(F_MTLO, 32'h22, 32'h11, 32'h22);
    run_md(F_DIV, 32'd5, 32'd0, F_MFHI, 32'h11, 32'h22, 10, 11);
`else
    // div in E is a no-op: no Start, no Busy, no stall, HI/LO unchanged
    cyc();
    OpE = 6'd0; FunctE = F_DIV; ValidE = 1'b1; A = 32'd9; B = 32'd2; OpD = 6'd0; FunctD = F_MFHI;
    @(negedge clk);
    check("div_off_start", 64'(Start), 64'd0);
    check("div_off_stall", 64'(MDStallD), 64'd0);
    cyc();
    ValidE = 1'b0; FunctE = F_ADDU; FunctD = F_ADDU;
    @(negedge clk);
    check("div_off_busy", 64'(Busy), 64'd0);
    repeat (12) @(negedge clk);
    check("div_off_hi", 64'(HI), 64'h1);
    check("div_off_lo", 64'(LO), 64'h23456780);
`endif

    // Reset during RUN: in-flight mult discarded, HI/LO cleared
    cyc();
    OpE = 6'd0; FunctE = F_MULT; ValidE = 1'b1; A = 32'd7; B = 32'd6;
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd42; e.n = 5;
      q.push_back(e);
    end
    cyc();
    ValidE = 1'b0; FunctE = F_ADDU;
    cyc();
    begin
      exp_t e;
      e.hi = 32'd0; e.lo = 32'd0; e.n = 0;
      q.delete();
      q.push_back(e);
    end
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("rst_run_busy", 64'(Busy), 64'd0);
    check("rst_run_hi", 64'(HI), 64'd0);
    check("rst_run_lo", 64'(LO), 64'd0);
    repeat (8) @(negedge clk);
    check("rst_nocommit_lo", 64'(LO), 64'd0);

    // Start coincident with reset is dropped
    cyc();
    reset = 1'b1; OpE = 6'd0; FunctE = F_MULT; ValidE = 1'b1; A = 32'd3; B = 32'd3;
    cyc();
    reset = 1'b0; ValidE = 1'b0; FunctE = F_ADDU;
    @(negedge clk);
    check("rst_start_busy", 64'(Busy), 64'd0);
    repeat (8) @(negedge clk);
    check("rst_start_lo", 64'(LO), 64'd0);

    check("queue_empty", 64'(q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
